// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative shift-add multiplier / restoring divider with register-file write-back.
// Define MULDIV_SIGNED_EN for two's complement operands and results (default: unsigned).
module mul_div_unit #(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] OperandA,
    input  logic [WIDTH-1:0] OperandB,
    input  logic [2:0]       DestAddress,
    output logic             Busy,
    output logic             Done,
    output logic             DivByZero,
    output logic [WIDTH-1:0] WriteData,
    output logic [2:0]       WriteAddress,
    output logic             ReadWriteEn
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, CALC, WB} state_t;
    state_t           r_state, w_next;
    logic [CW-1:0]    r_cnt;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_opnd, r_hi, r_lo;
    logic [2:0]       r_dest;
    logic             r_bz;
    logic             w_go, w_last, w_ge;
    logic [WIDTH-1:0] w_ma, w_mb, w_diff, w_hi_n, w_lo_n, w_res;
    logic [WIDTH:0]   w_sum, w_shift;

    assign w_go   = (r_state == IDLE) && Start;
    assign w_last = (r_state == CALC) && (r_cnt == CW'(WIDTH - 1));

    always_comb begin
        w_next      = w_go ? CALC : w_last ? WB : (r_state == CALC) ? CALC : IDLE;
        Busy        = r_state != IDLE;
        Done        = r_state == WB;
        ReadWriteEn = (r_state == WB) && (WriteAddress != 3'd0);
    end

    // Multiply: {r_hi,r_lo} is the product/multiplier pair; divide: r_hi is the remainder, r_lo the quotient.
    always_comb begin
        w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : '0);
        w_shift = {r_hi, r_lo[WIDTH-1]};
        w_ge    = w_shift >= {1'b0, r_opnd};
        w_diff  = w_shift[WIDTH-1:0] - r_opnd;
        w_hi_n  = r_op[1] ? (w_ge ? w_diff : w_shift[WIDTH-1:0]) : w_sum[WIDTH:1];
        w_lo_n  = r_op[1] ? {r_lo[WIDTH-2:0], w_ge} : {w_sum[0], r_lo[WIDTH-1:1]};
    end

`ifdef MULDIV_SIGNED_EN
    logic                 r_sa, r_sb;
    logic [2*WIDTH-1:0]   w_prod, w_prod_f;
    logic [WIDTH-1:0]     w_q, w_r;
    assign w_ma = OperandA[WIDTH-1] ? -OperandA : OperandA;
    assign w_mb = OperandB[WIDTH-1] ? -OperandB : OperandB;
    // Sign fix-up applied to the final iteration's outputs, so WB sees the signed result directly.
    always_comb begin
        w_prod   = {w_hi_n, w_lo_n};
        w_prod_f = (r_sa ^ r_sb) ? -w_prod : w_prod;
        w_q      = ((r_sa ^ r_sb) && !r_bz) ? -w_lo_n : w_lo_n;
        w_r      = r_sa ? -w_hi_n : w_hi_n;
        w_res    = r_op[1] ? (r_op[0] ? w_r : w_q)
                           : (r_op[0] ? w_prod_f[2*WIDTH-1:WIDTH] : w_prod_f[WIDTH-1:0]);
    end
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_sa <= 1'b0;
            r_sb <= 1'b0;
        end else if (w_go) begin
            r_sa <= OperandA[WIDTH-1];
            r_sb <= OperandB[WIDTH-1];
        end
    end
`else
    assign w_ma  = OperandA;
    assign w_mb  = OperandB;
    assign w_res = r_op[0] ? w_hi_n : w_lo_n;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_op         <= '0;
            r_opnd       <= '0;
            r_hi         <= '0;
            r_lo         <= '0;
            r_dest       <= '0;
            r_bz         <= 1'b0;
            WriteData    <= '0;
            WriteAddress <= '0;
            DivByZero    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_go) begin
                r_cnt  <= '0;
                r_op   <= Op;
                r_opnd <= Op[1] ? w_mb : w_ma;
                r_hi   <= '0;
                r_lo   <= Op[1] ? w_ma : w_mb;
                r_dest <= DestAddress;
                r_bz   <= Op[1] && (OperandB == '0);
            end else if (r_state == CALC) begin
                r_cnt <= r_cnt + 1'b1;
                r_hi  <= w_hi_n;
                r_lo  <= w_lo_n;
            end
            if (w_last) begin
                WriteData    <= w_res;
                WriteAddress <= r_dest;
                DivByZero    <= r_bz;
            end
        end
    end
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed vector table, randomized ops against an arithmetic model, and corner sequences.
module tb_mul_div_unit;
    localparam int W  = 16;
    localparam int W2 = 2 * W;

    logic         CLK = 1'b0, RST_N = 1'b0, Start = 1'b0;
    logic [1:0]   Op = '0;
    logic [W-1:0] OperandA = '0, OperandB = '0;
    logic [2:0]   DestAddress = '0;
    logic         Busy, Done, DivByZero, ReadWriteEn;
    logic [W-1:0] WriteData;
    logic [2:0]   WriteAddress;

    int errors = 0, checks = 0;

    mul_div_unit #(.WIDTH(W)) dut (
        .CLK(CLK), .RST_N(RST_N), .Start(Start), .Op(Op),
        .OperandA(OperandA), .OperandB(OperandB), .DestAddress(DestAddress),
        .Busy(Busy), .Done(Done), .DivByZero(DivByZero), .WriteData(WriteData),
        .WriteAddress(WriteAddress), .ReadWriteEn(ReadWriteEn)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a, b;
        logic [2:0]   d;
        logic [W-1:0] exp;
        logic         dbz;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Returns {DivByZero, WriteData} from plain arithmetic on the operands.
    function automatic logic [W:0] model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W2-1:0] p;
        logic [W-1:0]  q, r;
`ifdef MULDIV_SIGNED_EN
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = W2'(sa * sb);
        q  = (sb == 0) ? '1 : W'(sa / sb);
        r  = (sb == 0) ? a : W'(sa % sb);
`else
        p = W2'(a) * W2'(b);
        q = (b == '0) ? '1 : a / b;
        r = (b == '0) ? a : a % b;
`endif
        return {op[1] && (b == '0), (op == 2'd0) ? p[W-1:0] : (op == 2'd1) ? p[W2-1:W] : (op == 2'd2) ? q : r};
    endfunction

    // mode 0: plain op; 1: extra Start mid-CALC; 2: Start held in the WB cycle.
    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2:0] d, input logic [W:0] exp, input int mode);
        int k, seen;
        @(negedge CLK);
        Op = op; OperandA = a; OperandB = b; DestAddress = d; Start = 1'b1;
        @(posedge CLK); #1;
        Start = 1'b0;
        Op = 2'($urandom); OperandA = W'($urandom); OperandB = W'($urandom); DestAddress = 3'($urandom);
        chk("busy_after_capture", Busy, 1);
        k = 0;
        while (!Done && k < 40) begin
            Start = (mode == 1) && (k == 5);
            @(posedge CLK); #1;
            k++;
        end
        Start = 1'b0;
        // Done rises after the W-th edge following capture, i.e. in the (W+1)th cycle.
        chk("latency", k, W);
        chk("wdata", WriteData, exp[W-1:0]);
        chk("dbz", DivByZero, exp[W]);
        chk("waddr", WriteAddress, d);
        chk("rwe_wb", ReadWriteEn, d != 3'd0);
        if (mode == 2) Start = 1'b1;
        @(posedge CLK); #1;
        Start = 1'b0;
        chk("done_one_cycle", {Done, ReadWriteEn, Busy}, 0);
        chk("wdata_hold", WriteData, exp[W-1:0]);
        chk("waddr_hold", WriteAddress, d);
        if (mode != 0) begin
            seen = 0;
            repeat (W + 6) begin
                @(posedge CLK); #1;
                seen += int'(Done) + int'(Busy);
            end
            chk("no_queued_start", seen, 0);
        end
    endtask

    initial begin
        vec_t tbl[8];
        logic [1:0]   op;
        logic [W-1:0] a, b;
        logic [2:0]   d;
        int           seen;

        tbl[0] = '{2'd0, 16'h0123, 16'h0010, 3'd3, 16'h1230, 1'b0};
        tbl[1] = '{2'd1, 16'hFFFF, 16'hFFFF, 3'd5,
`ifdef MULDIV_SIGNED_EN
                   16'h0000,
`else
                   16'hFFFE,
`endif
                   1'b0};
        tbl[2] = '{2'd2, 16'd100, 16'd7, 3'd1, 16'd14, 1'b0};
        tbl[3] = '{2'd3, 16'd100, 16'd7, 3'd2, 16'd2, 1'b0};
        tbl[4] = '{2'd3, 16'hFF9C, 16'd7, 3'd4,
`ifdef MULDIV_SIGNED_EN
                   16'hFFFE,
`else
                   16'h0000,
`endif
                   1'b0};
        tbl[5] = '{2'd2, 16'h1234, 16'h0000, 3'd6, 16'hFFFF, 1'b1};
        tbl[6] = '{2'd3, 16'h1234, 16'h0000, 3'd7, 16'h1234, 1'b1};
        tbl[7] = '{2'd0, 16'h00FF, 16'h0101, 3'd0, 16'hFFFF, 1'b0};

        repeat (2) @(posedge CLK);
        #1;
        chk("rst_outputs", {Busy, Done, DivByZero, ReadWriteEn, WriteData, WriteAddress}, 0);
        @(negedge CLK);
        RST_N = 1'b1;

        foreach (tbl[i]) run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].d, {tbl[i].dbz, tbl[i].exp}, 0);

        run_op(2'd0, 16'h0123, 16'h0010, 3'd3, 17'h01230, 1);
        run_op(2'd2, 16'd100, 16'd7, 3'd0, 17'd14, 2);

        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = W'($urandom);
            b  = (i % 6 == 0) ? '0 : W'($urandom);
            d  = 3'($urandom_range(0, 7));
            run_op(op, a, b, d, model(op, a, b), 0);
        end

        // Reset at iteration 8 of a MULLO must clear everything and suppress the write.
        @(negedge CLK);
        Op = 2'd0; OperandA = 16'h4321; OperandB = 16'h0003; DestAddress = 3'd2; Start = 1'b1;
        @(posedge CLK); #1;
        Start = 1'b0;
        repeat (8) @(posedge CLK);
        #2;
        RST_N = 1'b0;
        #1;
        chk("rst_mid_calc", {Busy, Done, DivByZero, ReadWriteEn, WriteData, WriteAddress}, 0);
        seen = 0;
        repeat (W + 4) begin
            @(posedge CLK); #1;
            seen += int'(ReadWriteEn) + int'(Done) + int'(Busy);
        end
        chk("rst_no_strobe", seen, 0);
        @(negedge CLK);
        RST_N = 1'b1;
        run_op(2'd1, 16'h4321, 16'h8003, 3'd6, model(2'd1, 16'h4321, 16'h8003), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
